tiny_eth_mii_rx: RTL and testbench

Receive-side MII front end of the tiny_eth MAC, clocked by the PHY receive clock. It strips preamble/SFD from the nibble stream, assembles bytes low nibble first, and checks FCS (CRC-32), frame length and nibble alignment. It emits a registered byte stream with start/end markers and per-frame error flags to the MAC receive datapath. There is no backpressure because MII cannot stall.

---
 rtl/tiny_eth_mii_rx.sv | 194 +++++++++++++++++++
 tb/tb_tiny_eth_mii_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_eth_mii_rx.sv
// tiny_eth MII receive front end: preamble/SFD strip, nibble-to-byte
// assembly, FCS/length/alignment checks, registered byte stream out.
module tiny_eth_mii_rx #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic        i_rx_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_rx_data,
  input  logic        i_rx_en,
  input  logic        i_rx_er,
  output logic [7:0]  o_m_data,
  output logic        o_m_valid,
  output logic        o_m_sof,
  output logic        o_m_eof,
  output logic        o_m_err_crc,
  output logic        o_m_err_len,
  output logic        o_m_err_align,
  output logic        o_m_err_rxer,
  output logic [10:0] o_m_frame_len
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] LEN_MIN     = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] LEN_MAX     = 11'(MAX_FRAME_BYTES);
  localparam logic [10:0] LEN_OVF     = 11'(MAX_FRAME_BYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DROP
  } state_t;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] crc,
    input logic [7:0]  b
  );
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  logic [1:0]  r_rst_sync;
  logic        w_rst;

  state_t      r_state;
  logic [3:0]  r_low;
  logic        r_phase;
  logic [31:0] r_crc;
  logic [10:0] r_len;
  logic [7:0]  r_hold;
  logic        r_have;
  logic        r_first;
  logic        r_rxer;
  logic        r_ovf;

  logic [7:0]  w_byte;
  logic [31:0] w_crc_nx;
  logic [10:0] w_len_nx;
  logic        w_len_bad;

  // Reset asserts at once but releases only on a clock edge.
  always_ff @(posedge i_rx_clk or posedge i_rst) begin
    if (i_rst) r_rst_sync <= 2'b11;
    else       r_rst_sync <= {r_rst_sync[0], 1'b0};
  end

  assign w_rst     = r_rst_sync[1];
  assign w_byte    = {i_rx_data, r_low};
  assign w_crc_nx  = crc_byte(r_crc, w_byte);
  assign w_len_nx  = (r_len == 11'h7FF) ? r_len : r_len + 11'd1;
  assign w_len_bad = (r_len < LEN_MIN) || (r_len > LEN_MAX);

  always_ff @(posedge i_rx_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state       <= S_DROP;
      r_low         <= 4'd0;
      r_phase       <= 1'b0;
      r_crc         <= 32'hFFFFFFFF;
      r_len         <= 11'd0;
      r_hold        <= 8'd0;
      r_have        <= 1'b0;
      r_first       <= 1'b0;
      r_rxer        <= 1'b0;
      r_ovf         <= 1'b0;
      o_m_data      <= 8'd0;
      o_m_valid     <= 1'b0;
      o_m_sof       <= 1'b0;
      o_m_eof       <= 1'b0;
      o_m_err_crc   <= 1'b0;
      o_m_err_len   <= 1'b0;
      o_m_err_align <= 1'b0;
      o_m_err_rxer  <= 1'b0;
      o_m_frame_len <= 11'd0;
    end else begin
      o_m_valid     <= 1'b0;
      o_m_sof       <= 1'b0;
      o_m_eof       <= 1'b0;
      o_m_err_crc   <= 1'b0;
      o_m_err_len   <= 1'b0;
      o_m_err_align <= 1'b0;
      o_m_err_rxer  <= 1'b0;
      o_m_frame_len <= 11'd0;
      case (r_state)
        S_DROP: begin
          if (!i_rx_en) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (i_rx_en) begin
            if (i_rx_data == 4'h5 && !i_rx_er) r_state <= S_PRE;
            else                               r_state <= S_DROP;
          end
        end
        S_PRE: begin
          if (!i_rx_en) begin
            r_state <= S_IDLE;
          end else if (i_rx_er) begin
            r_state <= S_DROP;
          end else if (i_rx_data == 4'h5) begin
            r_state <= S_PRE;
          end else if (i_rx_data == 4'hD) begin
            r_state <= S_DATA;
            r_crc   <= 32'hFFFFFFFF;
            r_len   <= 11'd0;
            r_phase <= 1'b0;
            r_rxer  <= 1'b0;
            r_have  <= 1'b0;
            r_ovf   <= 1'b0;
          end else begin
            r_state <= S_DROP;
          end
        end
        S_DATA: begin
          if (r_ovf) begin
            // Oversize: close the frame on the byte that crossed the limit.
            o_m_valid     <= 1'b1;
            o_m_data      <= r_hold;
            o_m_sof       <= r_first;
            o_m_eof       <= 1'b1;
            o_m_err_crc   <= (r_crc != CRC_RESIDUE);
            o_m_err_len   <= 1'b1;
            o_m_err_align <= r_phase;
            o_m_err_rxer  <= r_rxer;
            o_m_frame_len <= r_len;
            r_have        <= 1'b0;
            r_ovf         <= 1'b0;
            r_state       <= S_DROP;
          end else if (!i_rx_en) begin
            if (r_have) begin
              o_m_valid     <= 1'b1;
              o_m_data      <= r_hold;
              o_m_sof       <= r_first;
              o_m_eof       <= 1'b1;
              o_m_err_crc   <= (r_crc != CRC_RESIDUE);
              o_m_err_len   <= w_len_bad;
              o_m_err_align <= r_phase;
              o_m_err_rxer  <= r_rxer | i_rx_er;
              o_m_frame_len <= r_len;
            end
            r_have  <= 1'b0;
            r_phase <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (i_rx_er) r_rxer <= 1'b1;
            if (!r_phase) begin
              r_low   <= i_rx_data;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              r_crc   <= w_crc_nx;
              r_len   <= w_len_nx;
              r_hold  <= w_byte;
              r_have  <= 1'b1;
              r_first <= !r_have;
              if (r_have) begin
                o_m_valid <= 1'b1;
                o_m_data  <= r_hold;
                o_m_sof   <= r_first;
              end
              if (w_len_nx == LEN_OVF) r_ovf <= 1'b1;
            end
          end
        end
        default: r_state <= S_DROP;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_eth_mii_rx.sv
// Self-checking bench for tiny_eth_mii_rx: table of frame cases,
// hand-written corner sequences and randomized frames vs a frame-level model.
module tb_tiny_eth_mii_rx;

  localparam int MINB = 64;
  localparam int MAXB = 1518;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rx_data;
  logic        rx_en;
  logic        rx_er;
  logic [7:0]  m_data;
  logic        m_valid, m_sof, m_eof;
  logic        m_err_crc, m_err_len, m_err_align, m_err_rxer;
  logic [10:0] m_frame_len;

  tiny_eth_mii_rx #(
    .MIN_FRAME_BYTES(MINB),
    .MAX_FRAME_BYTES(MAXB)
  ) dut (
    .i_rx_clk     (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_en      (rx_en),
    .i_rx_er      (rx_er),
    .o_m_data     (m_data),
    .o_m_valid    (m_valid),
    .o_m_sof      (m_sof),
    .o_m_eof      (m_eof),
    .o_m_err_crc  (m_err_crc),
    .o_m_err_len  (m_err_len),
    .o_m_err_align(m_err_align),
    .o_m_err_rxer (m_err_rxer),
    .o_m_frame_len(m_frame_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        sof, eof, ecrc, elen, ealign, erxer;
    logic [10:0] flen;
    int          cyc;
  } beat_t;

  typedef struct {
    int          n;
    int          flip;
    bit          extra;
    int          er_at;
    logic [10:0] flen;
    logic        ecrc, elen, ealign, erxer;
  } case_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         hi2_cyc;
  int         en_low_cyc;
  logic [7:0] tx_bytes[$];
  beat_t      got[$];
  beat_t      exp_q[$];
  case_t      tbl[9];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    beat_t b;
    if (m_valid === 1'b1) begin
      b.d = m_data; b.sof = m_sof; b.eof = m_eof;
      b.ecrc = m_err_crc; b.elen = m_err_len;
      b.ealign = m_err_align; b.erxer = m_err_rxer;
      b.flen = m_frame_len; b.cyc = cyc;
      got.push_back(b);
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Register value (before final inversion) after the first cnt bytes.
  function automatic logic [31:0] crc_reg(input int cnt);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ tx_bytes[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  task automatic gen_frame(input int n, input int flip);
    logic [31:0] f;
    tx_bytes.delete();
    for (int i = 0; i < n - 4; i++) tx_bytes.push_back(8'($urandom));
    f = ~crc_reg(n - 4);
    for (int i = 0; i < 4; i++) tx_bytes.push_back(f[8*i +: 8]);
    if (flip >= 0) tx_bytes[flip/8][flip%8] = ~tx_bytes[flip/8][flip%8];
  endtask

  function automatic logic fcs_bad(input int m);
    logic [31:0] f;
    if (m < 4) return 1'b1;
    f = ~crc_reg(m - 4);
    return {tx_bytes[m-1], tx_bytes[m-2], tx_bytes[m-3], tx_bytes[m-4]} != f;
  endfunction

  task automatic push_expected(input int m, input logic ecrc,
                               input logic elen, input logic ealign,
                               input logic erxer, input logic [10:0] flen);
    beat_t b;
    for (int i = 0; i < m; i++) begin
      b.d = tx_bytes[i]; b.sof = (i == 0); b.eof = (i == m - 1);
      b.ecrc = b.eof & ecrc; b.elen = b.eof & elen;
      b.ealign = b.eof & ealign; b.erxer = b.eof & erxer;
      b.flen = b.eof ? flen : 11'd0; b.cyc = 0;
      exp_q.push_back(b);
    end
  endtask

  // Frame-level reference: what the receiver must report for tx_bytes.
  task automatic model_expected(input bit extra, input int er_at);
    int n, m;
    logic over;
    n = tx_bytes.size();
    over = (n > MAXB);
    m = over ? MAXB + 1 : n;
    if (m == 0) return;
    push_expected(m, fcs_bad(m), over || (m < MINB), !over && extra,
                  (er_at >= 0) && (er_at < 2 * m), 11'(m));
  endtask

  task automatic nib(input logic [3:0] d, input logic en, input logic er);
    @(negedge clk);
    rx_data = d; rx_en = en; rx_er = er;
  endtask

  task automatic drive_frame(input bit pre_bad, input bit extra,
                             input int er_at, input int gap);
    for (int i = 0; i < 15; i++) nib((pre_bad && i == 3) ? 4'h7 : 4'h5, 1, 0);
    nib(4'hD, 1, 0);
    for (int i = 0; i < tx_bytes.size(); i++) begin
      nib(tx_bytes[i][3:0], 1, er_at == 2 * i);
      nib(tx_bytes[i][7:4], 1, er_at == 2 * i + 1);
      if (i == 1) hi2_cyc = cyc;
    end
    if (extra) nib(4'hA, 1, 0);
    nib(4'h0, 0, 0);
    en_low_cyc = cyc;
    repeat (gap - 1) nib(4'h0, 0, 0);
  endtask

  task automatic compare_all(input bit timing);
    int nd, nm, nsp, lim;
    nd = 0; nm = 0; nsp = 0;
    chk("beat_count", 64'(got.size()), 64'(exp_q.size()));
    lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      if (got[i].d !== exp_q[i].d) nd++;
      if (got[i].sof !== exp_q[i].sof || got[i].eof !== exp_q[i].eof) nm++;
      if (exp_q[i].eof)
        chk("eof_flags_len",
            {got[i].ecrc, got[i].elen, got[i].ealign, got[i].erxer, got[i].flen},
            {exp_q[i].ecrc, exp_q[i].elen, exp_q[i].ealign, exp_q[i].erxer,
             exp_q[i].flen});
      if (i > 0 && !exp_q[i].sof && !exp_q[i].eof &&
          got[i].cyc - got[i-1].cyc != 2) nsp++;
    end
    chk("data_mismatches", 64'(nd), 0);
    chk("marker_mismatches", 64'(nm), 0);
    chk("beat_spacing_errors", 64'(nsp), 0);
    if (timing && got.size() > 1) begin
      chk("sof_cycle", 64'(got[0].cyc), 64'(hi2_cyc + 1));
      chk("eof_cycle", 64'(got[got.size()-1].cyc), 64'(en_low_cyc + 1));
    end
    got.delete();
    exp_q.delete();
  endtask

  function automatic logic [25:0] all_outs();
    return {m_data, m_valid, m_sof, m_eof, m_err_crc, m_err_len,
            m_err_align, m_err_rxer, m_frame_len};
  endfunction

  initial begin
    tbl[0] = '{64,   -1,  0, -1, 11'd64,   0, 0, 0, 0};
    tbl[1] = '{64,   100, 0, -1, 11'd64,   1, 0, 0, 0};
    tbl[2] = '{64,   -1,  1, -1, 11'd64,   0, 0, 1, 0};
    tbl[3] = '{60,   -1,  0, -1, 11'd60,   0, 1, 0, 0};
    tbl[4] = '{64,   -1,  0, 10, 11'd64,   0, 0, 0, 1};
    tbl[5] = '{63,   -1,  0, -1, 11'd63,   0, 1, 0, 0};
    tbl[6] = '{1518, -1,  0, -1, 11'd1518, 0, 0, 0, 0};
    tbl[7] = '{1519, -1,  0, -1, 11'd1519, 0, 1, 0, 0};
    tbl[8] = '{64,   500, 0, -1, 11'd64,   1, 0, 0, 0};

    rst = 1'b1; rx_data = 4'h0; rx_en = 1'b0; rx_er = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(all_outs()), 0);
    rst = 1'b0;
    repeat (5) nib(4'h0, 0, 0);
    chk("idle_no_valid", 64'(m_valid), 0);
    got.delete();

    for (int t = 0; t < 9; t++) begin
      gen_frame(tbl[t].n, tbl[t].flip);
      drive_frame(0, tbl[t].extra, tbl[t].er_at, 4);
      push_expected((tbl[t].n > MAXB) ? MAXB + 1 : tbl[t].n,
                    tbl[t].ecrc, tbl[t].elen, tbl[t].ealign, tbl[t].erxer,
                    tbl[t].flen);
      compare_all(1);
    end

    // Bad preamble nibble: the whole frame is ignored.
    gen_frame(64, -1);
    drive_frame(1, 0, -1, 4);
    chk("bad_preamble_beats", 64'(got.size()), 0);
    got.delete();

    // Oversize frame truncates at MAX+1 bytes.
    gen_frame(1600, -1);
    drive_frame(0, 0, -1, 4);
    model_expected(0, -1);
    compare_all(0);

    // Reset mid-DATA with rx_en held high.
    gen_frame(64, -1);
    for (int i = 0; i < 15; i++) nib(4'h5, 1, 0);
    nib(4'hD, 1, 0);
    for (int i = 0; i < 20; i++) begin
      nib(tx_bytes[i][3:0], 1, 0);
      nib(tx_bytes[i][7:4], 1, 0);
    end
    nib(tx_bytes[20][3:0], 1, 0);
    chk("valid_before_rst", 64'(m_valid), 1);
    #1 rst = 1'b1;
    #1 chk("rst_clears_outputs", 64'(all_outs()), 0);
    got.delete();
    for (int i = 0; i < 30; i++) begin
      nib((i % 8 == 7) ? 4'hD : 4'h5, 1, 0);
      if (i == 3) rst = 1'b0;
    end
    repeat (3) nib(4'h0, 0, 0);
    chk("beats_after_rst", 64'(got.size()), 0);
    got.delete();
    gen_frame(64, -1);
    drive_frame(0, 0, -1, 4);
    model_expected(0, -1);
    compare_all(1);

    // Randomized frames, back-to-back with short gaps.
    for (int k = 0; k < 8; k++) begin
      int n, flip, er_at, gap;
      bit extra;
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 63)
                                      : $urandom_range(64, 160);
      flip = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8 * n - 1) : -1;
      extra = ($urandom_range(0, 3) == 0);
      er_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2 * n - 1) : -1;
      gap = $urandom_range(1, 3);
      gen_frame(n, flip);
      model_expected(extra, er_at);
      drive_frame(0, extra, er_at, gap);
    end
    repeat (4) nib(4'h0, 0, 0);
    compare_all(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
